// File: rtl/ic_bvashr_cmp_search.sv
// Invertibility-condition engine for signed comparisons over arithmetic shift right:
// evaluates the closed-form condition and cross-checks it with an exhaustive witness search.
module ic_bvashr_cmp_search #(
  parameter int W     = 4,
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ic_closed,
  output logic         ic_search,
  output logic [W-1:0] witness,
  output logic         mismatch,
  output logic [W:0]   cycles,
  output logic [1:0]   fsm_state
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. out_valid
  // and every result output stay constant until that transfer.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] OP_SGT = 2'd0;
  localparam logic [1:0] OP_SGE = 2'd1;
  localparam logic [1:0] OP_SLT = 2'd2;

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  state_t       state, state_nx;
  logic [1:0]   op_q;
  logic [W-1:0] s_q, t_q;
  logic [W:0]   base;
  logic [W:0]   base_next;
  logic         last_batch;
  logic         hit_any;
  logic [W-1:0] hit_x;
  logic [W-1:0] cand;
  logic         closed_in;

  // Shift amounts of W or more saturate instead of wrapping.
  function automatic logic [W-1:0] lsr(input logic [W-1:0] v, input logic [W-1:0] sh);
    if (int'(sh) >= W) return '0;
    return v >> sh;
  endfunction

  function automatic logic [W-1:0] asr(input logic [W-1:0] v, input logic [W-1:0] sh);
    if (int'(sh) >= W) return {W{v[W-1]}};
    return $signed(v) >>> sh;
  endfunction

  function automatic logic cmp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      OP_SGT:  return $signed(a) >  $signed(b);
      OP_SGE:  return $signed(a) >= $signed(b);
      OP_SLT:  return $signed(a) <  $signed(b);
      default: return $signed(a) <= $signed(b);
    endcase
  endfunction

  always_comb begin
    closed_in = 1'b0;
    case (op)
      OP_SGT:  closed_in = $signed(t) <  $signed(lsr(SMAX, s));
      OP_SGE:  closed_in = $signed(t) <= $signed(lsr(SMAX, s));
      OP_SLT:  closed_in = $signed(t) >  $signed(asr(SMIN, s));
      default: closed_in = $signed(t) >= $signed(asr(SMIN, s));
    endcase
  end

  // Lanes are scanned from the top down so the lowest hit is the one that sticks.
  always_comb begin
    hit_any = 1'b0;
    hit_x   = '0;
    cand    = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      cand = base[W-1:0] + W'(i);
      if (cmp(op_q, asr(cand, s_q), t_q)) begin
        hit_any = 1'b1;
        hit_x   = cand;
      end
    end
  end

  // base is always a multiple of LANES, so the batch that reaches 2^W is the last.
  assign base_next  = base + (W+1)'(LANES);
  assign last_batch = base_next[W];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SEARCH;
      SEARCH:  if (hit_any || last_batch) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      s_q       <= '0;
      t_q       <= '0;
      base      <= '0;
      cycles    <= '0;
      ic_closed <= 1'b0;
      ic_search <= 1'b0;
      witness   <= '0;
      mismatch  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q      <= op;
            s_q       <= s;
            t_q       <= t;
            base      <= '0;
            cycles    <= '0;
            ic_closed <= closed_in;
            ic_search <= 1'b0;
            witness   <= '0;
            mismatch  <= 1'b0;
          end
        end
        SEARCH: begin
          cycles <= cycles + (W+1)'(1);
          base   <= base_next;
          if (hit_any) begin
            ic_search <= 1'b1;
            witness   <= hit_x;
            mismatch  <= ~ic_closed;
          end else if (last_batch) begin
            ic_search <= 1'b0;
            witness   <= '0;
            mismatch  <= ic_closed;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_ic_bvashr_cmp_search.sv
// Bench for ic_bvashr_cmp_search: four W=4 instances (LANES 1, 2, 4, 16) share one request
// stream; directed vectors, backpressure, mid-search reset and a full op/s/t sweep.
module tb_ic_bvashr_cmp_search;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] op;
  logic [3:0] s, t;

  logic       rdy  [N];
  logic       ov   [N];
  logic       icc  [N];
  logic       ics  [N];
  logic [3:0] wit  [N];
  logic       mm   [N];
  logic [4:0] cyc  [N];
  logic [1:0] fsm  [N];
  int         lat  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ic_bvashr_cmp_search #(.W(4), .LANES(1 << ((g == 3) ? 4 : g))) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[g]),
      .op(op), .s(s), .t(t), .out_valid(ov[g]), .out_ready(out_ready),
      .ic_closed(icc[g]), .ic_search(ics[g]), .witness(wit[g]),
      .mismatch(mm[g]), .cycles(cyc[g]), .fsm_state(fsm[g])
    );
  end

  function automatic int lanes_of(input int g);
    return (g == 3) ? 16 : (1 << g);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // lat[g] = index of the rising edge (accept edge = 0) at which out_valid is first sampled high.
  task automatic run_req(input logic [1:0] o, input logic [3:0] sv, input logic [3:0] tv);
    bit all_done;
    @(negedge clk);
    op = o; s = sv; t = tv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int g = 0; g < N; g++) lat[g] = 0;
    all_done = 1'b0;
    for (int n = 0; n <= 40 && !all_done; n++) begin
      all_done = 1'b1;
      for (int g = 0; g < N; g++) begin
        if (ov[g] && lat[g] == 0) lat[g] = n + 1;
        if (lat[g] == 0) all_done = 1'b0;
      end
      if (!all_done) @(negedge clk);
    end
    if (!all_done) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Brute-force reference in plain integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [3:0] sv, input logic [3:0] tv,
                       output bit found, output int wx);
    int ts, xs, y;
    logic [3:0] xv;
    bit ok;
    found = 1'b0;
    wx = 0;
    ts = $signed(tv);
    for (int x = 15; x >= 0; x--) begin
      xv = 4'(x);
      xs = $signed(xv);
      if (sv >= 4) y = (xs < 0) ? -1 : 0;
      else y = xs >>> sv;
      case (o)
        2'd0:    ok = y >  ts;
        2'd1:    ok = y >= ts;
        2'd2:    ok = y <  ts;
        default: ok = y <= ts;
      endcase
      if (ok) begin
        found = 1'b1;
        wx = x;
      end
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] s;
    logic [3:0] t;
    int         g;
    bit         closed;
    bit         srch;
    int         wit;
    int         cyc;
    int         lat;
  } vec_t;

  vec_t tab[7];

  initial begin
    bit   found;
    int   wx, ec;
    string nm;

    tab[0] = '{2'd0, 4'd0,  4'd7,  0, 1'b0, 1'b0, 0, 16, 17};
    tab[1] = '{2'd0, 4'd1,  4'd2,  0, 1'b1, 1'b1, 6,  7,  8};
    tab[2] = '{2'd2, 4'd5,  4'd0,  0, 1'b1, 1'b1, 8,  9, 10};
    tab[3] = '{2'd1, 4'd3,  4'd0,  2, 1'b1, 1'b1, 0,  1,  2};
    tab[4] = '{2'd3, 4'd0,  4'h8,  2, 1'b1, 1'b1, 8,  3,  4};
    tab[5] = '{2'd2, 4'd0,  4'h8,  0, 1'b0, 1'b0, 0, 16, 17};
    tab[6] = '{2'd3, 4'd15, 4'hf,  3, 1'b1, 1'b1, 8,  1,  2};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; s = '0; t = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("reset_in_ready", rdy[g], 1);
      chk("reset_out_valid", ov[g], 0);
      chk("reset_ic_closed", icc[g], 0);
      chk("reset_ic_search", ics[g], 0);
      chk("reset_witness", wit[g], 0);
      chk("reset_mismatch", mm[g], 0);
      chk("reset_cycles", cyc[g], 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_req(tab[i].op, tab[i].s, tab[i].t);
      chk($sformatf("vec%0d_ic_closed", i), icc[tab[i].g], tab[i].closed);
      chk($sformatf("vec%0d_ic_search", i), ics[tab[i].g], tab[i].srch);
      chk($sformatf("vec%0d_witness", i), wit[tab[i].g], tab[i].wit);
      chk($sformatf("vec%0d_mismatch", i), mm[tab[i].g], 0);
      chk($sformatf("vec%0d_cycles", i), cyc[tab[i].g], tab[i].cyc);
      chk($sformatf("vec%0d_latency", i), lat[tab[i].g], tab[i].lat);
      release_result();
    end

    // Backpressure: five cycles held in DONE with a stray request in the middle.
    run_req(2'd0, 4'd1, 4'd2);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        op = 2'd2; s = 4'd0; t = 4'd0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_out_valid", ov[0], 1);
      chk("bp_in_ready", rdy[0], 0);
      chk("bp_witness", wit[0], 6);
      chk("bp_cycles", cyc[0], 7);
      chk("bp_ic_search", ics[0], 1);
    end
    in_valid = 1'b0;
    release_result();
    chk("bp_after_out_valid", ov[0], 0);
    chk("bp_after_in_ready", rdy[0], 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) chk("bp_no_second_transfer", ov[g], 0);
    end

    // Reset during SEARCH cycle 3.
    @(negedge clk);
    op = 2'd0; s = 4'd0; t = 4'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_state", fsm[0], 1);
    chk("rst_pre_cycles", cyc[0], 3);
    rst_n = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("rst_state_idle", fsm[g], 0);
      chk("rst_out_valid", ov[g], 0);
      chk("rst_cycles", cyc[g], 0);
      chk("rst_in_ready", rdy[g], 1);
    end
    rst_n = 1'b1;
    run_req(2'd0, 4'd1, 4'd2);
    chk("post_rst_witness", wit[0], 6);
    chk("post_rst_cycles", cyc[0], 7);
    chk("post_rst_latency", lat[0], 8);
    release_result();

    // Full sweep of op, s, t across all lane counts.
    for (int o = 0; o < 4; o++) begin
      for (int sv = 0; sv < 16; sv++) begin
        for (int tv = 0; tv < 16; tv++) begin
          model(2'(o), 4'(sv), 4'(tv), found, wx);
          for (int g = 0; g < N; g++) begin
            ec = found ? (wx / lanes_of(g) + 1) : (16 / lanes_of(g));
            nm = $sformatf("sw_L%0d_op%0d_s%0d_t%0d", lanes_of(g), o, sv, tv);
            if (g == 0) run_req(2'(o), 4'(sv), 4'(tv));
            chk({nm, "_mismatch"}, mm[g], 0);
            chk({nm, "_ic_search"}, ics[g], found);
            chk({nm, "_ic_closed"}, icc[g], found);
            chk({nm, "_witness"}, wit[g], wx);
            chk({nm, "_cycles"}, cyc[g], ec);
            chk({nm, "_latency"}, lat[g], ec + 1);
          end
          release_result();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
